axi_stream_master_pkt: RTL and testbench

Parametrised AXI4-Stream master source for the zynq_aes benches and data-movement paths. Words are pushed into an internal circular data FIFO. Packet lengths are pushed into a separate length FIFO. The block replays the words as framed packets, with tlast on the final beat of each packet. Adds per-packet framing, overflow/error reporting, beat/packet counters and optional inter-beat throttling.

---
 rtl/axi_stream_master_pkt.sv | 234 +++++++++++++++++++++++
 tb/tb_axi_stream_master_pkt.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_master_pkt.sv
// ---------------------------------------------------------------------------
// axi_stream_master_pkt
//
// AXI4-Stream master packet source. Words are written into a circular data
// FIFO and packet lengths into a separate length FIFO. A small FSM replays
// the queued words as framed packets and asserts tlast on the final beat of
// each packet.
//
// Optional feature macro: AXIS_MASTER_THROTTLE_EN
//   When this macro is defined, every accepted beat loads a gap counter from
//   gap_cycles, and the next beat cannot load until that counter drains. With
//   gap_cycles = G and tready held high, consecutive beats are G+1 cycles
//   apart. When the macro is undefined, gap_cycles is ignored.
//
// Ports:
//   m00_axis_aclk / m00_axis_aresetn : clock, asynchronous active-low reset
//   wr_en, wr_data, wr_full          : data FIFO push interface
//   pkt_wr_en, pkt_len, pkt_full     : length FIFO push interface
//                                      (a length of 0 is rejected)
//   gap_cycles                       : idle cycles after each beat (throttle)
//   m00_axis_t*                      : AXI4-Stream master interface
//   idle                             : FSM idle, no beat held, no length queued
//   err                              : sticky flag for any dropped write
//   beats_sent / pkts_sent           : wrapping handshake counters
// ---------------------------------------------------------------------------
module axi_stream_master_pkt #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 2048,
  parameter int PKT_FIFO_DEPTH       = 16,
  parameter int LEN_WIDTH            = 16
) (
  input  logic                                m00_axis_aclk,
  input  logic                                m00_axis_aresetn,
  input  logic                                wr_en,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     wr_data,
  output logic                                wr_full,
  input  logic                                pkt_wr_en,
  input  logic [LEN_WIDTH-1:0]                pkt_len,
  output logic                                pkt_full,
  input  logic [7:0]                          gap_cycles,
  output logic                                m00_axis_tvalid,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tlast,
  input  logic                                m00_axis_tready,
  output logic                                idle,
  output logic                                err,
  output logic [31:0]                         beats_sent,
  output logic [15:0]                         pkts_sent
);

  localparam int DW = C_M_AXIS_TDATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(PKT_FIFO_DEPTH);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

  // Storage arrays and FIFO pointers. Each pointer carries one extra wrap bit.
  logic [DW-1:0]        dmem_q [FIFO_DEPTH];
  logic [LEN_WIDTH-1:0] pmem_q [PKT_FIFO_DEPTH];
  logic [AW:0]          dwr_q, drd_q, dwr_d, drd_d;
  logic [PW:0]          pwr_q, prd_q, pwr_d, prd_d;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;
  logic [DW-1:0]        tdata_q, tdata_d;
  logic                 err_q, err_d;
  logic [31:0]          beats_q, beats_d;
  logic [15:0]          pkts_q, pkts_d;

  logic d_empty_s, d_full_s, p_empty_s, p_full_s;
  logic d_push_s, p_push_s, d_pop_s, p_pop_s;
  logic drop_s, hs_s, gap_free_s;

  // FIFO status. The full flags depend on the current pointers only, so a
  // write that arrives while full is dropped even if a pop happens that cycle.
  assign d_empty_s = (dwr_q == drd_q);
  assign d_full_s  = (dwr_q[AW] != drd_q[AW]) && (dwr_q[AW-1:0] == drd_q[AW-1:0]);
  assign p_empty_s = (pwr_q == prd_q);
  assign p_full_s  = (pwr_q[PW] != prd_q[PW]) && (pwr_q[PW-1:0] == prd_q[PW-1:0]);

  assign d_push_s = wr_en && !d_full_s;
  assign p_push_s = pkt_wr_en && !p_full_s && (pkt_len != {LEN_WIDTH{1'b0}});
  assign drop_s   = (wr_en && d_full_s) ||
                    (pkt_wr_en && (p_full_s || (pkt_len == {LEN_WIDTH{1'b0}})));
  assign hs_s     = tvalid_q && m00_axis_tready;

`ifdef AXIS_MASTER_THROTTLE_EN
  logic [7:0] gap_q, gap_d;

  // Gap counter next value. Loads are gated on the next value, so a gap of G
  // gives G idle cycles between beats (beats are G+1 cycles apart).
  always_comb begin
    gap_d = gap_q;
    if (hs_s) begin
      gap_d = gap_cycles;
    end else if (gap_q != 8'd0) begin
      gap_d = gap_q - 8'd1;
    end else begin
      gap_d = 8'd0;
    end
  end
  assign gap_free_s = (gap_d == 8'd0);

  // Gap counter register.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      gap_q <= 8'd0;
    end else begin
      gap_q <= gap_d;
    end
  end
`else
  logic unused_gap_s;
  assign unused_gap_s = ^gap_cycles;
  assign gap_free_s   = 1'b1;
`endif

  // Packet FSM, output register load and FIFO pop control.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    d_pop_s  = 1'b0;
    p_pop_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Data availability is checked per beat in SEND, not here.
        if (!p_empty_s) begin
          p_pop_s = 1'b1;
          rem_d   = pmem_q[prd_q[PW-1:0]];
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if ((!tvalid_q || hs_s) && !d_empty_s &&
            (rem_q != {LEN_WIDTH{1'b0}}) && gap_free_s) begin
          tdata_d  = dmem_q[drd_q[AW-1:0]];
          tvalid_d = 1'b1;
          tlast_d  = (rem_q == {{(LEN_WIDTH-1){1'b0}}, 1'b1});
          d_pop_s  = 1'b1;
          rem_d    = rem_q - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
        end else if (hs_s) begin
          // Beat taken with nothing to follow: drop valid. The packet is
          // done if that beat was the last one, otherwise it is an underrun.
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          if (tlast_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase
  end

  // Pointer, counter and error next-state values.
  always_comb begin
    dwr_d   = d_push_s ? (dwr_q + {{AW{1'b0}}, 1'b1}) : dwr_q;
    drd_d   = d_pop_s  ? (drd_q + {{AW{1'b0}}, 1'b1}) : drd_q;
    pwr_d   = p_push_s ? (pwr_q + {{PW{1'b0}}, 1'b1}) : pwr_q;
    prd_d   = p_pop_s  ? (prd_q + {{PW{1'b0}}, 1'b1}) : prd_q;
    err_d   = err_q | drop_s;
    beats_d = hs_s ? (beats_q + 32'd1) : beats_q;
    pkts_d  = (hs_s && tlast_q) ? (pkts_q + 16'd1) : pkts_q;
  end

  // FIFO storage writes; contents need no reset since pointers gate reads.
  always_ff @(posedge m00_axis_aclk) begin
    if (d_push_s) begin
      dmem_q[dwr_q[AW-1:0]] <= wr_data;
    end
    if (p_push_s) begin
      pmem_q[pwr_q[PW-1:0]] <= pkt_len;
    end
  end

  // State, pointer, output and counter registers.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q  <= ST_IDLE;
      rem_q    <= {LEN_WIDTH{1'b0}};
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= {DW{1'b0}};
      dwr_q    <= {(AW+1){1'b0}};
      drd_q    <= {(AW+1){1'b0}};
      pwr_q    <= {(PW+1){1'b0}};
      prd_q    <= {(PW+1){1'b0}};
      err_q    <= 1'b0;
      beats_q  <= 32'd0;
      pkts_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      dwr_q    <= dwr_d;
      drd_q    <= drd_d;
      pwr_q    <= pwr_d;
      prd_q    <= prd_d;
      err_q    <= err_d;
      beats_q  <= beats_d;
      pkts_q   <= pkts_d;
    end
  end

  assign wr_full         = d_full_s;
  assign pkt_full        = p_full_s;
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tlast  = tlast_q;
  assign m00_axis_tstrb  = {(DW/8){1'b1}};
  assign idle            = (state_q == ST_IDLE) && !tvalid_q && p_empty_s;
  assign err             = err_q;
  assign beats_sent      = beats_q;
  assign pkts_sent       = pkts_q;

endmodule

// File: tb/tb_axi_stream_master_pkt.sv
// Testbench for axi_stream_master_pkt: directed packets, scoreboard of
// expected beats checked by an independent monitor on the falling edge.
module tb_axi_stream_master_pkt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_full;
  logic        pkt_wr_en;
  logic [15:0] pkt_len;
  logic        pkt_full;
  logic [7:0]  gap_cycles;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        tready;
  logic        idle;
  logic        err;
  logic [31:0] beats_sent;
  logic [15:0] pkts_sent;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_count = 0;
  logic [32:0] exp_q[$];
  int hs_q[$];

`ifdef AXIS_MASTER_THROTTLE_EN
  localparam int THR_SPACING = 4;
`else
  localparam int THR_SPACING = 1;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  axi_stream_master_pkt dut (
    .m00_axis_aclk   (clk),
    .m00_axis_aresetn(rst_n),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .wr_full         (wr_full),
    .pkt_wr_en       (pkt_wr_en),
    .pkt_len         (pkt_len),
    .pkt_full        (pkt_full),
    .gap_cycles      (gap_cycles),
    .m00_axis_tvalid (tvalid),
    .m00_axis_tdata  (tdata),
    .m00_axis_tstrb  (tstrb),
    .m00_axis_tlast  (tlast),
    .m00_axis_tready (tready),
    .idle            (idle),
    .err             (err),
    .beats_sent      (beats_sent),
    .pkts_sent       (pkts_sent)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: sample on the falling edge what the next rising edge will see.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tvalid && tready) begin
        hs_q.push_back(cyc);
        hs_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {31'd0, tlast, tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("beat_data", {32'd0, tdata}, {32'd0, exp_q[0][31:0]});
          chk("beat_last", {63'd0, tlast}, {63'd0, exp_q[0][32]});
          void'(exp_q.pop_front());
        end
      end else if (tvalid) begin
        // Stalled beat must be the expected one and held unchanged.
        if (exp_q.size() == 0) begin
          chk("stall_unexpected", {31'd0, tlast, tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("stall_data", {32'd0, tdata}, {32'd0, exp_q[0][31:0]});
          chk("stall_last", {63'd0, tlast}, {63'd0, exp_q[0][32]});
        end
      end
    end
  end

  task automatic push_word(input logic [31:0] d, input logic last);
    wr_en = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    exp_q.push_back({last, d});
  endtask

  task automatic push_len(input logic [15:0] len, output int n);
    pkt_wr_en = 1'b1;
    pkt_len = len;
    @(posedge clk);
    #1;
    n = cyc;
    pkt_wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    bit done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0 && idle) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", {63'd0, done}, 64'd1);
  endtask

  task automatic chk_counts(input string tag, input int beats, input int pkts);
    chk({tag, "_beats"}, {32'd0, beats_sent}, beats);
    chk({tag, "_pkts"}, {48'd0, pkts_sent}, pkts);
    chk({tag, "_idle"}, {63'd0, idle}, 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    hs_q.delete();
  endtask

  initial begin
    int n;
    int n2;
    int base;
    bit seen;
    rst_n = 1'b0;
    wr_en = 1'b0;
    wr_data = 32'd0;
    pkt_wr_en = 1'b0;
    pkt_len = 16'd0;
    gap_cycles = 8'd0;
    tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_tvalid", {63'd0, tvalid}, 64'd0);
    chk("rst_tlast", {63'd0, tlast}, 64'd0);
    chk("rst_tdata", {32'd0, tdata}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_full", {62'd0, wr_full, pkt_full}, 64'd0);
    chk("rst_strb", {60'd0, tstrb}, 64'hF);
    chk_counts("rst", 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: 4-beat packet, back to back, first valid 2 edges after length
    hs_q.delete();
    for (int i = 0; i < 4; i++) push_word(32'hA0 + i, i == 3);
    push_len(16'd4, n);
    wait_drain(50);
    chk("t1_nhs", hs_q.size(), 4);
    if (hs_q.size() == 4) begin
      chk("t1_latency", hs_q[0] - n, 2);
      for (int i = 1; i < 4; i++) chk("t1_spacing", hs_q[i] - hs_q[i-1], 1);
    end
    chk_counts("t1", 4, 1);

    // Test 2: stall on beat 2 for 3 cycles
    tready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'hA0 + i, i == 3);
    push_len(16'd4, n);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tvalid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("t2_valid_seen", {63'd0, seen}, 64'd1);
    tready = 1'b1;
    @(posedge clk);
    #1;
    tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tready = 1'b1;
    wait_drain(50);
    chk_counts("t2", 8, 2);

    // Test 3: two queued packets, lengths 2 and 3
    hs_q.delete();
    for (int i = 0; i < 5; i++) push_word(32'hE0 + i, (i == 1) || (i == 4));
    push_len(16'd2, n);
    push_len(16'd3, n2);
    wait_drain(60);
    chk("t3_nhs", hs_q.size(), 5);
    if (hs_q.size() == 5) begin
      chk("t3_sp01", hs_q[1] - hs_q[0], 1);
      chk("t3_gap", hs_q[2] - hs_q[1], 3);
      chk("t3_sp23", hs_q[3] - hs_q[2], 1);
      chk("t3_sp34", hs_q[4] - hs_q[3], 1);
    end
    chk_counts("t3", 13, 4);

    // Test 6: throttle spacing (back-to-back without the feature)
    hs_q.delete();
    gap_cycles = 8'd3;
    for (int i = 0; i < 3; i++) push_word(32'hD0 + i, i == 2);
    push_len(16'd3, n);
    wait_drain(80);
    chk("t6_nhs", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      chk("t6_sp1", hs_q[1] - hs_q[0], THR_SPACING);
      chk("t6_sp2", hs_q[2] - hs_q[1], THR_SPACING);
    end
    gap_cycles = 8'd0;
    chk_counts("t6", 16, 5);

    // Test 4: fill data FIFO, overflow write dropped, then drain it all
    wr_en = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      wr_data = 32'h1000_0000 + i;
      exp_q.push_back({(i == 2047), 32'h1000_0000 + i});
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    chk("t4_full", {63'd0, wr_full}, 64'd1);
    chk("t4_err_before", {63'd0, err}, 64'd0);
    wr_en = 1'b1;
    wr_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    chk("t4_err_overflow", {63'd0, err}, 64'd1);
    push_len(16'd2048, n);
    wait_drain(2200);
    chk_counts("t4", 2064, 6);
    chk("t4_empty", {63'd0, wr_full}, 64'd0);

    // Test 4b: zero length rejected after a clean reset
    do_reset();
    chk("t4b_err_clear", {63'd0, err}, 64'd0);
    push_len(16'd0, n);
    repeat (3) @(posedge clk);
    #1;
    chk("t4b_err", {63'd0, err}, 64'd1);
    chk("t4b_idle", {63'd0, idle}, 64'd1);
    chk("t4b_tvalid", {63'd0, tvalid}, 64'd0);

    // Test 5: asynchronous reset mid-packet
    do_reset();
    chk("t5_err_clear", {63'd0, err}, 64'd0);
    for (int i = 0; i < 4; i++) wr_data = 32'h0;
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 32'hB0 + i;
      if (i < 2) exp_q.push_back({1'b0, 32'hB0 + i});
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    base = hs_count;
    push_len(16'd4, n);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (hs_count == base + 2) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("t5_two_beats", {63'd0, seen}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_tvalid_async", {63'd0, tvalid}, 64'd0);
    chk("t5_full", {62'd0, wr_full, pkt_full}, 64'd0);
    chk_counts("t5_rst", 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    push_word(32'hC5, 1'b1);
    push_len(16'd1, n);
    wait_drain(30);
    chk_counts("t5_after", 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
